// File: rtl/time_seek_pkg.sv
// Shared definitions for the BCD mm:ss to RAM address seek converter.
// Optional clamp-to-track-length behaviour is selected with TIME_SEEK_CLAMP_EN.
package time_seek_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } seek_state_t;

    localparam int MIN_TENS_HI  = 15;
    localparam int MIN_TENS_LO  = 12;
    localparam int MIN_UNITS_HI = 11;
    localparam int MIN_UNITS_LO = 8;
    localparam int SEC_TENS_HI  = 7;
    localparam int SEC_TENS_LO  = 4;
    localparam int SEC_UNITS_HI = 3;
    localparam int SEC_UNITS_LO = 0;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    // A time is legal when every digit is decimal and the seconds stay below 60.
    function automatic logic bcd_time_valid(input logic [15:0] t);
        return (t[MIN_TENS_HI:MIN_TENS_LO]   <= BCD_DIGIT_MAX) &&
               (t[MIN_UNITS_HI:MIN_UNITS_LO] <= BCD_DIGIT_MAX) &&
               (t[SEC_TENS_HI:SEC_TENS_LO]   <= SEC_TENS_MAX)  &&
               (t[SEC_UNITS_HI:SEC_UNITS_LO] <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/time_seek_bcd_sec_dec.sv
// Combinational one-second decrement of a BCD mm:ss value.
// Borrows ripple from second units up to minute tens; is_zero flags an input of 00:00.
module bcd_sec_dec
    import time_seek_pkg::*;
(
    input  logic [15:0] time_in,
    output logic [15:0] time_dec,
    output logic        is_zero
);

    always_comb begin
        time_dec = time_in;
        is_zero  = (time_in == 16'h0000);
        if (time_in[SEC_UNITS_HI:SEC_UNITS_LO] != 4'd0) begin
            time_dec[SEC_UNITS_HI:SEC_UNITS_LO] = time_in[SEC_UNITS_HI:SEC_UNITS_LO] - 4'd1;
        end else if (time_in[SEC_TENS_HI:SEC_TENS_LO] != 4'd0) begin
            time_dec[SEC_UNITS_HI:SEC_UNITS_LO] = BCD_DIGIT_MAX;
            time_dec[SEC_TENS_HI:SEC_TENS_LO]   = time_in[SEC_TENS_HI:SEC_TENS_LO] - 4'd1;
        end else if (time_in[MIN_UNITS_HI:MIN_UNITS_LO] != 4'd0) begin
            time_dec[SEC_UNITS_HI:SEC_UNITS_LO]   = BCD_DIGIT_MAX;
            time_dec[SEC_TENS_HI:SEC_TENS_LO]     = SEC_TENS_MAX;
            time_dec[MIN_UNITS_HI:MIN_UNITS_LO]   = time_in[MIN_UNITS_HI:MIN_UNITS_LO] - 4'd1;
        end else begin
            time_dec[SEC_UNITS_HI:SEC_UNITS_LO]   = BCD_DIGIT_MAX;
            time_dec[SEC_TENS_HI:SEC_TENS_LO]     = SEC_TENS_MAX;
            time_dec[MIN_UNITS_HI:MIN_UNITS_LO]   = BCD_DIGIT_MAX;
            time_dec[MIN_TENS_HI:MIN_TENS_LO]     = time_in[MIN_TENS_HI:MIN_TENS_LO] - 4'd1;
        end
    end

endmodule

// File: rtl/time_seek.sv
// Iterative BCD mm:ss to RAM address converter: one second consumed per clock.
// Define TIME_SEEK_CLAMP_EN to limit the result to the latched music_len.
module time_seek
    import time_seek_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int ADDR_PER_SEC = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              seek_req,
    input  logic [15:0]       seek_time,
    input  logic [ADDR_W-1:0] music_len,
    output logic              busy,
    output logic              seek_valid,
    output logic [ADDR_W-1:0] seek_addr,
    output logic              clamped,
    output logic              err
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_PER_SEC);

    seek_state_t       state;
    seek_state_t       next_state;
    logic [15:0]       time_q;
    logic [ADDR_W-1:0] acc_q;
    logic [15:0]       time_dec;
    logic              time_is_zero;
    logic              time_valid;
    logic              clamp_hit;
    logic [ADDR_W-1:0] acc_step;

    bcd_sec_dec u_dec (
        .time_in  (time_q),
        .time_dec (time_dec),
        .is_zero  (time_is_zero)
    );

    assign time_valid = bcd_time_valid(time_q);
    assign acc_step   = acc_q + STEP;

`ifdef TIME_SEEK_CLAMP_EN
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W:0]   acc_sum;
    logic              clamped_q;

    // Compare one bit wider so an accumulator near the top cannot wrap past the limit.
    assign acc_sum   = {1'b0, acc_q} + {1'b0, STEP};
    assign clamp_hit = (acc_sum > {1'b0, len_q});
    assign clamped   = clamped_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            len_q     <= '0;
            clamped_q <= 1'b0;
        end else begin
            if (state == IDLE && seek_req) begin
                len_q <= music_len;
            end
            if (state == CHECK && (!time_valid || time_is_zero)) begin
                clamped_q <= 1'b0;
            end else if (state == COUNT && (clamp_hit || time_dec == 16'h0000)) begin
                clamped_q <= clamp_hit;
            end
        end
    end
`else
    logic len_unused;
    assign len_unused = ^music_len;
    assign clamp_hit  = 1'b0;
    assign clamped    = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (seek_req) next_state = CHECK;
            CHECK:   next_state = (!time_valid || time_is_zero) ? DONE : COUNT;
            COUNT:   if (clamp_hit || time_dec == 16'h0000) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        seek_valid = (state == DONE);
    end

    // Results are loaded on the edge into DONE so they are valid alongside seek_valid.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            time_q    <= '0;
            acc_q     <= '0;
            seek_addr <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seek_req) begin
                        time_q <= seek_time;
                        acc_q  <= '0;
                    end
                end
                CHECK: begin
                    if (!time_valid) begin
                        err <= 1'b1;
                    end else if (time_is_zero) begin
                        err       <= 1'b0;
                        seek_addr <= '0;
                    end
                end
                COUNT: begin
                    time_q <= time_dec;
`ifdef TIME_SEEK_CLAMP_EN
                    acc_q  <= clamp_hit ? len_q : acc_step;
`else
                    acc_q  <= acc_step;
`endif
                    if (clamp_hit || time_dec == 16'h0000) begin
                        err <= 1'b0;
`ifdef TIME_SEEK_CLAMP_EN
                        seek_addr <= clamp_hit ? len_q : acc_step;
`else
                        seek_addr <= acc_step;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_seek.sv
// Self-checking bench for time_seek: directed table, corner sequences and random seeks.
// Expectations follow TIME_SEEK_CLAMP_EN the same way the design does.
module tb_time_seek;

    localparam int LIMIT = 7000;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        seek_req;
    logic [15:0] seek_time;
    logic [11:0] music_len;
    logic        busy;
    logic        seek_valid;
    logic [11:0] seek_addr;
    logic        clamped;
    logic        err;

    int total;
    int bad;
    logic [11:0] last_addr;

    typedef struct {
        logic [15:0] t;
        logic [11:0] len;
        bit          extra;
        logic [11:0] addr;
        bit          clamp;
        bit          error;
        int          cycle;
        string       name;
    } vec_t;

    time_seek dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .seek_req   (seek_req),
        .seek_time  (seek_time),
        .music_len  (music_len),
        .busy       (busy),
        .seek_valid (seek_valid),
        .seek_addr  (seek_addr),
        .clamped    (clamped),
        .err        (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: total seconds times the step, optionally limited to the track length.
    function automatic void model(input logic [15:0] t, input logic [11:0] len, input logic [11:0] prev,
                                  output logic [11:0] ea, output bit ec, output bit ee, output int cyc);
        int mt, mu, st, su, n, full;
        mt = int'(t[15:12]);
        mu = int'(t[11:8]);
        st = int'(t[7:4]);
        su = int'(t[3:0]);
        ec = 1'b0;
        if (mt > 9 || mu > 9 || st > 5 || su > 9) begin
            ea = prev; ee = 1'b1; cyc = 2;
            return;
        end
        ee   = 1'b0;
        n    = (mt * 10 + mu) * 60 + st * 10 + su;
        full = n * 4;
`ifdef TIME_SEEK_CLAMP_EN
        if (full > int'(len)) begin
            ea = len; ec = 1'b1; cyc = int'(len) / 4 + 3;
            return;
        end
`endif
        ea  = 12'(full % 4096);
        cyc = n + 2;
    endfunction

    task automatic apply_stimulus(input logic [15:0] t, input logic [11:0] len, input bit extra,
                                  input logic [11:0] ea, input bit ec, input bit ee, input int ecyc,
                                  input string nm);
        int cyc, vcyc, busy_low, pulses;
        logic [11:0] a;
        logic c, e;
        a = 'x; c = 'x; e = 'x;
        @(negedge sys_clk);
        seek_time = t; music_len = len; seek_req = 1'b1;
        @(posedge sys_clk); #1;
        seek_req  = 1'b0;
        seek_time = 16'($urandom);
        music_len = 12'($urandom);
        cyc = 1; vcyc = -1; busy_low = 0;
        while (vcyc < 0 && cyc <= LIMIT) begin
            seek_req = (extra && cyc == 1);
            if (!busy) busy_low++;
            if (seek_valid) begin
                vcyc = cyc; a = seek_addr; c = clamped; e = err;
            end else begin
                @(posedge sys_clk); #1;
                cyc++;
            end
        end
        seek_req = 1'b0;
        check_output({nm, " valid_cycle"}, 32'(vcyc), 32'(ecyc));
        check_output({nm, " addr"}, 32'(a), 32'(ea));
        check_output({nm, " clamped"}, 32'(c), 32'(ec));
        check_output({nm, " err"}, 32'(e), 32'(ee));
        check_output({nm, " busy_low_while_active"}, 32'(busy_low), 32'd0);
        @(posedge sys_clk); #1;
        check_output({nm, " busy_after_done"}, 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (seek_valid) pulses++;
            @(posedge sys_clk); #1;
        end
        check_output({nm, " extra_valid"}, 32'(pulses), 32'd0);
        last_addr = ea;
    endtask

    initial begin
        vec_t vecs[6];
        logic [11:0] ea;
        bit ec, ee;
        int ecyc, pulses;
        logic [15:0] rt;
        logic [11:0] rl;

        total = 0; bad = 0; last_addr = '0;
        sys_rst_n = 1'b0; seek_req = 1'b0; seek_time = '0; music_len = '0;

        vecs[0] = '{16'h0005, 12'd100,  1'b0, 12'd20,  1'b0, 1'b0, 7,  "t0005"};
        vecs[1] = '{16'h0100, 12'd4095, 1'b0, 12'd240, 1'b0, 1'b0, 62, "t0100"};
`ifdef TIME_SEEK_CLAMP_EN
        vecs[2] = '{16'h0030, 12'd50,   1'b0, 12'd50,  1'b1, 1'b0, 15, "t0030"};
        vecs[3] = '{16'h007A, 12'd100,  1'b0, 12'd50,  1'b0, 1'b1, 2,  "t007A"};
        vecs[4] = '{16'h0060, 12'd100,  1'b0, 12'd50,  1'b0, 1'b1, 2,  "t0060"};
`else
        vecs[2] = '{16'h0030, 12'd50,   1'b0, 12'd120, 1'b0, 1'b0, 32, "t0030"};
        vecs[3] = '{16'h007A, 12'd100,  1'b0, 12'd120, 1'b0, 1'b1, 2,  "t007A"};
        vecs[4] = '{16'h0060, 12'd100,  1'b0, 12'd120, 1'b0, 1'b1, 2,  "t0060"};
`endif
        vecs[5] = '{16'h0000, 12'd100,  1'b1, 12'd0,   1'b0, 1'b0, 2,  "t0000"};

        repeat (2) @(posedge sys_clk);
        #1;
        check_output("rst busy", 32'(busy), 32'd0);
        check_output("rst seek_valid", 32'(seek_valid), 32'd0);
        check_output("rst seek_addr", 32'(seek_addr), 32'd0);
        check_output("rst clamped", 32'(clamped), 32'd0);
        check_output("rst err", 32'(err), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].t, vecs[i].len, vecs[i].extra, vecs[i].addr,
                           vecs[i].clamp, vecs[i].error, vecs[i].cycle, vecs[i].name);
        end

        // Reset in the middle of a 00:20 conversion.
        @(negedge sys_clk);
        seek_time = 16'h0020; music_len = 12'd4095; seek_req = 1'b1;
        @(posedge sys_clk); #1;
        seek_req = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge sys_clk); #1;
        end
        sys_rst_n = 1'b0;
        #1;
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst seek_valid", 32'(seek_valid), 32'd0);
        check_output("midrst seek_addr", 32'(seek_addr), 32'd0);
        check_output("midrst clamped", 32'(clamped), 32'd0);
        check_output("midrst err", 32'(err), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        last_addr = '0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge sys_clk); #1;
            if (seek_valid) pulses++;
        end
        check_output("midrst no_valid", 32'(pulses), 32'd0);
        model(16'h0020, 12'd4095, last_addr, ea, ec, ee, ecyc);
        apply_stimulus(16'h0020, 12'd4095, 1'b0, ea, ec, ee, ecyc, "after_rst");

        model(16'h9959, 12'd4095, last_addr, ea, ec, ee, ecyc);
        apply_stimulus(16'h9959, 12'd4095, 1'b0, ea, ec, ee, ecyc, "t9959");

        for (int i = 0; i < 20; i++) begin
            rt = {4'd0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))};
            rl = 12'($urandom_range(0, 1000));
            model(rt, rl, last_addr, ea, ec, ee, ecyc);
            apply_stimulus(rt, rl, 1'($urandom_range(0, 1)), ea, ec, ee, ecyc, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
